// File: rtl/uart_pkg.sv
// Shared UART constants for the 27 MHz fabric: line rate, bit timing and TX state encoding.
// Both the transmitter and the receiver derive their timing from these values.
package uart_pkg;

    localparam int CLK_HZ = 27000000;
    localparam int BAUD   = 115200;

    // Rounded down: 234.375 -> 234, about 0.16 % fast, well inside 8N1 tolerance.
    localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;
    localparam int CLKS_PER_BIT_HALF    = CLKS_PER_BIT_DEFAULT / 2;

    localparam int DATA_BITS = 8;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t TX_IDLE  = 3'd0;
    localparam tx_state_t TX_START = 3'd1;
    localparam tx_state_t TX_DATA  = 3'd2;
    localparam tx_state_t TX_STOP  = 3'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter; dout is valid whenever !empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; clearing the pointers already makes
    // every entry unreadable, and an unreset array maps onto plain RAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line driven straight from a flop.
// Bytes are queued in a small FIFO; queued frames go out back-to-back with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    state_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_t     state;
    logic [CW-1:0] clk_count;
    logic [2:0]    bit_index;
    logic [7:0]    sh;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          push;
    logic          pop;
    logic          terminal;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (tx_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // tx_ready depends only on the FIFO pointers, never on tx_valid.
    assign tx_ready  = !fifo_full;
    assign push      = tx_valid && tx_ready;
    assign terminal  = (clk_count == CW'(CLKS_PER_BIT - 1));
    assign busy      = (state != TX_IDLE) || (fifo_count != '0);
    assign state_out = state;

    always_comb begin
        // NOTE: assign a default before any branch; a path that leaves pop unassigned infers a latch.
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == TX_IDLE)                 pop = 1'b1;
            else if (state == TX_STOP && terminal) pop = 1'b1;
        end
    end

    // NOTE: every register here uses <= so all updates see pre-edge values, as the flops do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            tx        <= 1'b1;
            clk_count <= '0;
            bit_index <= '0;
            sh        <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    clk_count <= '0;
                    tx        <= 1'b1;
                    if (pop) begin
                        sh    <= fifo_dout;
                        tx    <= 1'b0;
                        state <= TX_START;
                    end
                end

                TX_START: begin
                    if (terminal) begin
                        clk_count <= '0;
                        tx        <= sh[0];
                        bit_index <= '0;
                        state     <= TX_DATA;
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                end

                TX_DATA: begin
                    if (terminal) begin
                        clk_count <= '0;
                        if (bit_index == 3'd7) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            sh        <= {1'b0, sh[7:1]};
                            tx        <= sh[1];
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                end

                TX_STOP: begin
                    if (terminal) begin
                        clk_count <= '0;
                        // A queued byte starts its start bit right after this stop bit.
                        if (pop) begin
                            sh    <= fifo_dout;
                            tx    <= 1'b0;
                            state <= TX_START;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + CW'(1);
                    end
                end

                default: begin
                    tx        <= 1'b1;
                    clk_count <= '0;
                    state     <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus a randomized run against a
// frame-level reference model (queue of pending bytes + countdown of the frame in flight).
module tb_uart_tx;
    import uart_pkg::*;

    localparam int C     = 16;
    localparam int CL    = CLKS_PER_BIT_DEFAULT;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int WLEN  = 16384;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx, tx_ready, busy;
    logic [CW-1:0] fifo_count;
    logic [2:0]    state_out;

    logic [7:0]    lb_data;
    logic          lb_valid;
    logic          lb_tx, lb_ready, lb_busy;
    logic [CW-1:0] lb_count;
    logic [2:0]    lb_state;

    int errors = 0;
    int checks = 0;

    logic          wave [WLEN];
    logic          rdy  [WLEN];
    logic          bsy  [WLEN];
    logic [CW-1:0] cnt  [WLEN];
    logic          lbw  [WLEN];

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .state_out(state_out)
    );

    uart_tx #(.CLKS_PER_BIT(CL), .FIFO_DEPTH(DEPTH)) dut_lb (
        .clk(clk), .rst_n(rst_n), .tx_data(lb_data), .tx_valid(lb_valid),
        .tx_ready(lb_ready), .tx(lb_tx), .busy(lb_busy), .fifo_count(lb_count),
        .state_out(lb_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Advance one clock and record outputs 1 time unit after the edge.
    task automatic tick(input int t);
        @(posedge clk);
        #1;
        if (t >= 0 && t < WLEN) begin
            wave[t] = tx;
            rdy[t]  = tx_ready;
            bsy[t]  = busy;
            cnt[t]  = fifo_count;
            lbw[t]  = lb_tx;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        lb_valid = 1'b0;
        tx_data  = '0;
        lb_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Line level of frame bit k (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic [9:0] sample_frame(input int start, input int c, input bit lb);
        logic [9:0] f;
        int t;
        f = '0;
        for (int k = 0; k < 10; k++) begin
            t = start + k * c + c / 2;
            if (t < WLEN) f[k] = lb ? lbw[t] : wave[t];
            else          f[k] = 1'bx;
        end
        return f;
    endfunction

    function automatic int wave_errs(input int start, input int c, input int n,
                                     input logic [7:0] bytes [8], input bit lb);
        int e;
        logic s;
        e = 0;
        for (int t = 0; t < n * 10 * c; t++) begin
            s = lb ? lbw[start + t] : wave[start + t];
            if (s !== frame_bit(bytes[t / (10 * c)], (t % (10 * c)) / c)) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_valid = i[0];
            tx_data  = 8'($urandom);
            lb_valid = i[0];
            lb_data  = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({tx, tx_ready, busy, state_out, fifo_count} !== {1'b1, 1'b1, 1'b0, TX_IDLE, CW'(0)}) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got tx=%b ready=%b busy=%b state=%0d count=%0d, want 1 1 0 0 0",
                         i, tx, tx_ready, busy, state_out, fifo_count);
            end
            checks++;
            if ({lb_tx, lb_ready, lb_busy, lb_state, lb_count} !== {1'b1, 1'b1, 1'b0, TX_IDLE, CW'(0)}) begin
                errors++;
                $display("FAIL reset_hold_lb cycle %0d: got tx=%b ready=%b busy=%b state=%0d count=%0d, want 1 1 0 0 0",
                         i, lb_tx, lb_ready, lb_busy, lb_state, lb_count);
            end
        end
        tx_valid = 1'b0;
        lb_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({tx, tx_ready, busy, state_out} !== {1'b1, 1'b1, 1'b0, TX_IDLE}) begin
            errors++;
            $display("FAIL reset_release: got tx=%b ready=%b busy=%b state=%0d, want 1 1 0 0",
                     tx, tx_ready, busy, state_out);
        end
    endtask

    task automatic test_single();
        logic [9:0] exp_seq;
        int t;
        exp_seq = 10'b1010101010;
        do_reset();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick(0);
        tx_valid = 1'b0;
        for (int i = 1; i <= 10 * C + 4; i++) tick(i);

        checks++;
        if (wave[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_accept_edge: tx=%b, want 1", wave[0]);
        end
        checks++;
        if (wave[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_fall_latency: tx=%b one cycle after accept, want 0", wave[1]);
        end
        for (int k = 0; k < 10; k++) begin
            t = 1 + k * C + 8;
            checks++;
            if (wave[t] !== exp_seq[k]) begin
                errors++;
                $display("FAIL single_bit%0d: tx=%b, want %b", k, wave[t], exp_seq[k]);
            end
        end
        checks++;
        if ({bsy[10 * C], bsy[10 * C + 1]} !== 2'b10) begin
            errors++;
            $display("FAIL single_busy_fall: busy at +159/+160 = %b%b, want 10", bsy[10 * C], bsy[10 * C + 1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [8];
        int e;
        logic [9:0] f;
        do_reset();
        b = '{8'hA3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        tick(0);
        tx_data  = 8'h0F;
        tick(1);
        tx_valid = 1'b0;
        for (int i = 2; i <= 20 * C + 4; i++) tick(i);

        checks++;
        if (cnt[1] !== CW'(1)) begin
            errors++;
            $display("FAIL b2b_push_pop_count: count=%0d, want 1", cnt[1]);
        end
        e = wave_errs(1, C, 2, b, 1'b0);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL b2b_waveform: %0d cycles differ from two contiguous frames, want 0", e);
        end
        for (int k = 0; k < 2; k++) begin
            f = sample_frame(1 + k * 10 * C, C, 1'b0);
            checks++;
            if (f !== {1'b1, b[k], 1'b0}) begin
                errors++;
                $display("FAIL b2b_decode%0d: frame=%b, want %b", k, f, {1'b1, b[k], 1'b0});
            end
        end
        checks++;
        if ({bsy[20 * C], bsy[20 * C + 1], wave[20 * C + 1]} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_busy_end: busy@319/320=%b%b tx=%b, want 10 1",
                     bsy[20 * C], bsy[20 * C + 1], wave[20 * C + 1]);
        end
    endtask

    task automatic test_full_fifo();
        logic [7:0] pre_ready;
        logic [7:0] exp_ready;
        logic [7:0] b [8];
        logic [9:0] f;
        int e;
        do_reset();
        exp_ready = 8'b0001_1111;
        for (int k = 1; k <= 8; k++) begin
            b[k-1]         = 8'(k);
            tx_data        = 8'(k);
            tx_valid       = 1'b1;
            pre_ready[k-1] = tx_ready;
            tick(k - 1);
        end
        tx_valid = 1'b0;
        for (int i = 8; i <= 50 * C + 6; i++) tick(i);

        checks++;
        if (pre_ready !== exp_ready) begin
            errors++;
            $display("FAIL full_accept_pattern: ready per byte=%b, want %b", pre_ready, exp_ready);
        end
        checks++;
        if ({rdy[7], cnt[7]} !== {1'b0, CW'(4)}) begin
            errors++;
            $display("FAIL full_state: ready=%b count=%0d, want 0 4", rdy[7], cnt[7]);
        end
        checks++;
        if ({rdy[10 * C], rdy[10 * C + 1], cnt[10 * C + 1]} !== {2'b01, CW'(3)}) begin
            errors++;
            $display("FAIL full_ready_return: ready before/after pop=%b%b count=%0d, want 01 3",
                     rdy[10 * C], rdy[10 * C + 1], cnt[10 * C + 1]);
        end
        e = wave_errs(1, C, 5, b, 1'b0);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL full_waveform: %0d cycles differ from frames 1..5, want 0", e);
        end
        for (int k = 0; k < 5; k++) begin
            f = sample_frame(1 + k * 10 * C, C, 1'b0);
            checks++;
            if (f[8:1] !== b[k]) begin
                errors++;
                $display("FAIL full_decode%0d: byte=%h, want %h", k, f[8:1], b[k]);
            end
        end
        checks++;
        if ({bsy[50 * C + 1], cnt[50 * C + 1], wave[50 * C + 6]} !== {1'b0, CW'(0), 1'b1}) begin
            errors++;
            $display("FAIL full_drain: busy=%b count=%0d tx=%b, want 0 0 1",
                     bsy[50 * C + 1], cnt[50 * C + 1], wave[50 * C + 6]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int te;
        int bad;
        do_reset();
        te = 1 + 4 * C + 5;
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
        tick(0);
        tx_data  = 8'($urandom);
        tick(1);
        tx_data  = 8'($urandom);
        tick(2);
        tx_valid = 1'b0;
        for (int i = 3; i <= te; i++) tick(i);

        checks++;
        if ({wave[te], cnt[te]} !== {1'b0, CW'(2)}) begin
            errors++;
            $display("FAIL midrst_before: tx=%b count=%0d in bit 3 of 0xF0, want 0 2", wave[te], cnt[te]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, tx_ready, busy, state_out, fifo_count} !== {1'b1, 1'b1, 1'b0, TX_IDLE, CW'(0)}) begin
            errors++;
            $display("FAIL midrst_async: tx=%b ready=%b busy=%b state=%0d count=%0d, want 1 1 0 0 0",
                     tx, tx_ready, busy, state_out, fifo_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30 * C; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== CW'(0) || state_out !== TX_IDLE) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrst_after: %0d cycles with activity after release, want 0", bad);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] b [8];
        logic [9:0] f;
        int pos, p, e;
        do_reset();
        b = '{8'h00, 8'hFF, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        lb_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lb_data = b[k];
            tick(k);
        end
        lb_valid = 1'b0;
        for (int i = 3; i <= 30 * CL + 4; i++) tick(i);

        // Bench-side receiver: hunt for the start edge, then sample each bit at its centre.
        pos = 0;
        for (int k = 0; k < 3; k++) begin
            p = pos;
            while (p < WLEN - 1 && lbw[p] !== 1'b0) p++;
            checks++;
            if (p !== 1 + k * 10 * CL) begin
                errors++;
                $display("FAIL lb_start%0d: start edge at cycle %0d, want %0d", k, p, 1 + k * 10 * CL);
            end
            f = sample_frame(p, CL, 1'b1);
            checks++;
            if (f !== {1'b1, b[k], 1'b0}) begin
                errors++;
                $display("FAIL lb_decode%0d: frame=%b, want %b", k, f, {1'b1, b[k], 1'b0});
            end
            pos = p + 9 * CL + CLKS_PER_BIT_HALF;
        end
        e = wave_errs(1, CL, 3, b, 1'b1);
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL lb_waveform: %0d cycles differ over 3 contiguous frames, want 0", e);
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] cur;
        int rem, j, bad, first_bad;
        logic [7:0] d;
        logic v, acc;
        logic exp_tx, exp_busy, exp_rdy;
        logic [2:0] exp_state;
        logic [CW-1:0] exp_cnt;
        logic [CW+5:0] got_vec, exp_vec, first_got, first_exp;
        cur = '0;
        rem = 0;
        bad = 0;
        first_bad = -1;
        first_got = '0;
        first_exp = '0;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ((cyc / 500) % 2 == 0) v = ($urandom_range(0, 1) == 1);
            else                      v = ($urandom_range(0, 63) == 0);
            d        = 8'($urandom);
            tx_valid = v;
            tx_data  = d;
            acc      = v && (q.size() < DEPTH);
            @(posedge clk);
            #1;
            // Model: a frame occupies 10*C cycles; the next byte starts on its last edge.
            if (rem > 1) rem--;
            else if (q.size() > 0) begin
                cur = q.pop_front();
                rem = 10 * C;
            end else rem = 0;
            if (acc) q.push_back(d);

            j         = (10 * C - rem) / C;
            exp_tx    = (rem == 0) ? 1'b1 : frame_bit(cur, j);
            exp_state = (rem == 0) ? TX_IDLE : (j == 0) ? TX_START : (j == 9) ? TX_STOP : TX_DATA;
            exp_busy  = (rem != 0) || (q.size() != 0);
            exp_cnt   = CW'(q.size());
            exp_rdy   = (q.size() < DEPTH);
            got_vec   = {tx, tx_ready, busy, state_out, fifo_count};
            exp_vec   = {exp_tx, exp_rdy, exp_busy, exp_state, exp_cnt};
            if (got_vec !== exp_vec) begin
                bad++;
                if (first_bad < 0) begin
                    first_bad = cyc;
                    first_got = got_vec;
                    first_exp = exp_vec;
                end
            end
        end
        tx_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL random_model: %0d cycles differ, first at %0d got {tx,rdy,busy,state,cnt}=%b want %b",
                     bad, first_bad, first_got, first_exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        lb_valid = 1'b0;
        lb_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_random();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
